ball_renderer: RTL and testbench

Raster-side consumer of the bouncing ball's bounding box. It generates the pixel raster: horizontal/vertical counters, sync pulses and an active-video flag. Once per frame it issues the `move` pulse that advances the ball. It latches the ball's `top/left/right/bottom` once per frame so the picture never tears, and outputs a registered `pixel` bit that is high inside the latched box. It sits between the ball model and the display output pins.

---
 rtl/ball_renderer_pkg.sv | 32 +++
 rtl/ball_renderer_timing.sv | 69 ++++++
 rtl/ball_renderer.sv | 104 ++++++++++
 tb/tb_ball_renderer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ball_renderer_pkg.sv
// rtl/ball_renderer_pkg.sv - shared screen geometry, default raster timing and box types
package ball_renderer_pkg;

  localparam int width  = 640;
  localparam int height = 480;
  localparam int xBits  = 10;
  localparam int yBits  = 9;

  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;

  // Common signed width wide enough for either axis plus a zero-extended counter
  localparam int CW = xBits + 2;

  typedef struct packed {
    logic signed [yBits:0] top;
    logic signed [xBits:0] left;
    logic signed [xBits:0] right;
    logic signed [yBits:0] bottom;
  } box_t;

  function automatic logic in_span(input logic signed [CW-1:0] c,
                                   input logic signed [CW-1:0] lo,
                                   input logic signed [CW-1:0] hi);
    return (lo <= c) && (c <= hi);
  endfunction

endpackage

// File: rtl/ball_renderer_timing.sv
// rtl/ball_renderer_timing.sv - raster h/v counters and raw sync/active/frame-event decodes
module raster_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          active_on,
  output logic          move_on,
  output logic          latch_on
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_wrap;

  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + HW'(1);
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h         = h_q;
  assign v         = v_q;
  assign hsync_on  = (h_q >= HS_START) && (h_q < HS_END);
  assign vsync_on  = (v_q >= VS_START) && (v_q < VS_END);
  assign active_on = (h_q < H_ACT) && (v_q < V_ACT);
  assign move_on   = (h_q == '0) && (v_q == V_ACT);
  // Latch on the last blanking line so the box is stable before line 0
  assign latch_on  = (h_q == '0) && (v_q == V_LAST);

endmodule

// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - raster generator that latches the ball box per frame and renders it
module ball_renderer
  import ball_renderer_pkg::*;
#(
  parameter int H_ACTIVE = width,
  parameter int H_FRONT  = H_FRONT_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BACK   = H_BACK_DEF,
  parameter int V_ACTIVE = height,
  parameter int V_FRONT  = V_FRONT_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [yBits:0] top,
  input  logic signed [xBits:0] left,
  input  logic signed [xBits:0] right,
  input  logic signed [yBits:0] bottom,
  output logic                  move,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  pixel,
  output logic [xBits:0]        hcount,
  output logic [yBits:0]        vcount
);

  logic [xBits:0] h;
  logic [yBits:0] v;
  logic hsync_on, vsync_on, active_on, move_on, latch_on;

  raster_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HW(xBits + 1), .VW(yBits + 1)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .h        (h),
    .v        (v),
    .hsync_on (hsync_on),
    .vsync_on (vsync_on),
    .active_on(active_on),
    .move_on  (move_on),
    .latch_on (latch_on)
  );

  box_t box_q, box_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic active_q, active_d, pixel_q, pixel_d, move_q, move_d;
  logic signed [CW-1:0] hx, vy, lx, rx, ty, by;
  logic lit;

  always_comb begin
    box_d = box_q;
    if (latch_on) begin
      box_d.top    = top;
      box_d.left   = left;
      box_d.right  = right;
      box_d.bottom = bottom;
    end
    // Counters are unsigned; a leading zero keeps them non-negative in signed compares
    hx  = $signed({1'b0, h});
    vy  = CW'($signed({1'b0, v}));
    lx  = CW'($signed(box_q.left));
    rx  = CW'($signed(box_q.right));
    ty  = CW'($signed(box_q.top));
    by  = CW'($signed(box_q.bottom));
    lit = in_span(hx, lx, rx) && in_span(vy, ty, by);
    hsync_d  = ~hsync_on;
    vsync_d  = ~vsync_on;
    active_d = active_on;
    pixel_d  = active_on && lit;
    move_d   = move_on;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      box_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      pixel_q  <= 1'b0;
      move_q   <= 1'b0;
    end else begin
      box_q    <= box_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      pixel_q  <= pixel_d;
      move_q   <= move_d;
    end
  end

  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign active = active_q;
  assign pixel  = pixel_q;
  assign move   = move_q;
  assign hcount = h;
  assign vcount = v;

endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - scoreboard bench for ball_renderer on a reduced raster
module tb_ball_renderer;

  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 56
  localparam int VT = VA + VF + VS + VB;   // 37
  localparam int F  = HT * VT;             // 2072

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [9:0]  top = '0, bottom = '0;
  logic signed [10:0] left = '0, right = '0;
  logic move, hsync, vsync, active, pixel;
  logic [10:0] hcount;
  logic [9:0]  vcount;

  ball_renderer #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset),
    .top(top), .left(left), .right(right), .bottom(bottom),
    .move(move), .hsync(hsync), .vsync(vsync), .active(active), .pixel(pixel),
    .hcount(hcount), .vcount(vcount)
  );

  always #5 clk = ~clk;

  int t = 0;
  always @(posedge clk) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  int checks = 0;
  int errors = 0;
  int exp_pix[$];
  int exp_move[$];
  int exp_hfall[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, req, t);
    end
  endtask

  logic move_prev = 1'b0, hs_prev = 1'b1, vs_prev = 1'b1;
  int hs_start = 0, vs_start = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pixel) begin
        if (exp_pix.size() == 0) chk("pixel_unexpected", t, -1);
        else chk("pixel_t", t, exp_pix.pop_front());
        chk("pixel_in_active", int'(active), 1);
      end
      if (move) begin
        chk("move_width", int'(move_prev), 0);
        if (exp_move.size() == 0) chk("move_unexpected", t, -1);
        else chk("move_t", t, exp_move.pop_front());
      end
      if (hs_prev && !hsync) begin
        hs_start = t;
        if (exp_hfall.size() > 0) chk("hsync_first_fall", t, exp_hfall.pop_front());
      end
      if (!hs_prev && hsync) chk("hsync_width", t - hs_start, HS);
      if (vs_prev && !vsync) vs_start = t;
      if (!vs_prev && vsync) chk("vsync_width", t - vs_start, VS * HT);
    end
    move_prev = move;
    hs_prev   = hsync;
    vs_prev   = vsync;
  end

  task automatic wait_until(input int target);
    int n = 0;
    while (t != target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_reached", t, target);
  endtask

  task automatic chk_reset_state();
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_active", int'(active), 0);
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_move", int'(move), 0);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
  endtask

  initial begin
    // Box A held across the first latch
    top = 10; left = 20; right = 23; bottom = 13;
    repeat (3) @(negedge clk);
    chk_reset_state();

    exp_hfall.push_back(HA + HF + 1);
    for (int k = 0; k < 3; k++) exp_move.push_back(VA * HT + 1 + k * F);
    exp_pix.push_back(1);
    for (int y = 10; y <= 13; y++)
      for (int x = 20; x <= 23; x++) exp_pix.push_back(F + y * HT + x + 1);
    for (int y = 0; y <= 3; y++)
      for (int x = 0; x <= 3; x++) exp_pix.push_back(2 * F + y * HT + x + 1);
    for (int y = 25; y <= 26; y++)
      for (int x = 30; x <= 31; x++) exp_pix.push_back(3 * F + y * HT + x + 1);
    reset = 1'b0;

    // Box B applied mid frame 1 (line 5)
    wait_until(F + 5 * HT);
    top = 0; left = -1; right = 3; bottom = 3;

    // Box C applied mid frame 2 (line 20)
    wait_until(2 * F + 20 * HT);
    top = 25; left = 30; right = 31; bottom = 26;

    // Reset at (h=25, v=28) of frame 3, before its move
    wait_until(3 * F + 28 * HT + 25);
    chk("pre_rst_hcount", int'(hcount), 25);
    chk("pre_rst_vcount", int'(vcount), 28);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state();
    exp_pix.push_back(1);
    exp_move.push_back(VA * HT + 1);
    reset = 1'b0;

    wait_until(VA * HT + 10);
    chk("pix_queue_left", exp_pix.size(), 0);
    chk("move_queue_left", exp_move.size(), 0);
    chk("hfall_queue_left", exp_hfall.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
